pe_nic: RTL and testbench

- Network interface controller between a processing element (PE) and the PE port of a cardinal ring router.
- Processor side: a small register file (addr/enable/write-enable) for posting outgoing packets and fetching received packets.
- Router side: drives the router's PE input channel (send/ready/data) and terminates the router's PE output channel.
- Outgoing packets are injected only in the clock phase matching their virtual-channel (VC) bit.

---
 rtl/pe_nic_pkg.sv | 18 +
 rtl/nic_fifo.sv | 78 +++++++
 rtl/pe_nic.sv | 116 +++++++++++
 tb/tb_pe_nic.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_nic_pkg.sv
// Shared constants for the PE network interface: register map, packet
// width and the position of the virtual-channel bit.
package pe_nic_pkg;

  localparam int DW     = 64;
  localparam int VC_BIT = 63;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  // Virtual channel a packet travels on: 0 = even cycle, 1 = odd cycle.
  function automatic logic vc_of(input logic [DW-1:0] pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/nic_fifo.sv
// Small synchronous FIFO used for both NIC directions. A push while full is
// accepted only when a pop happens in the same cycle; a pop while empty is
// ignored. The head word is presented combinationally.
module nic_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 64,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic full_s;
  logic empty_s;
  logic push_ok_s;
  logic pop_ok_s;

  // Pointer advance with explicit wrap so non-power-of-two-sized pointers stay in range.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign pop_ok_s  = pop && !empty_s;
  assign push_ok_s = push && (!full_s || pop_ok_s);

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/pe_nic.sv
// Network interface between a processing element and the PE port of a ring
// router. The processor posts packets to out_buf and fetches them from
// in_buf; outgoing packets leave only in the cycle phase matching their VC.
module pe_nic #(
  parameter int DEPTH = 2,
  parameter int DW    = 64,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  input  logic          nicEn,
  input  logic          nicWrEn,
  output logic          net_so,
  input  logic          net_ro,
  output logic [DW-1:0] net_do,
  input  logic          net_polarity,
  input  logic          net_si,
  output logic          net_ri,
  input  logic [DW-1:0] net_di
);

  import pe_nic_pkg::*;

  logic [DW-1:0] in_head_s;
  logic          in_full_s;
  logic          in_empty_s;
  logic [CW-1:0] in_count_s;
  logic [4:0]    in_cnt5_s;

  logic [DW-1:0] out_head_s;
  logic          out_full_s;
  logic          out_empty_s;
  logic [CW-1:0] out_count_s;
  logic [4:0]    out_cnt5_s;

  logic          rd_s;
  logic          rd_in_s;
  logic          wr_out_s;
  logic          in_push_s;
  logic          net_so_s;
  logic          net_ri_s;
  logic [DW-1:0] d_out_nxt_s;
  logic [DW-1:0] d_out_r;

  assign rd_s      = nicEn && !nicWrEn;
  assign rd_in_s   = rd_s && (addr == ADDR_IN_BUF);
  assign wr_out_s  = nicEn && nicWrEn && (addr == ADDR_OUT_BUF);

  // Router may only send while we have room; a send while full is dropped.
  assign net_ri_s  = !in_full_s;
  assign in_push_s = net_si && net_ri_s;

  // Head-of-line packet goes out only in its own polarity phase.
  assign net_so_s  = !out_empty_s && net_ro && (net_polarity == vc_of(out_head_s));

  assign in_cnt5_s  = 5'(in_count_s);
  assign out_cnt5_s = 5'(out_count_s);

  assign net_ri = net_ri_s;
  assign net_so = net_so_s;
  assign net_do = out_head_s;
  assign d_out  = d_out_r;

  nic_fifo #(.DEPTH(DEPTH), .DW(DW)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push_s),
    .pop   (rd_in_s),
    .din   (net_di),
    .dout  (in_head_s),
    .full  (in_full_s),
    .empty (in_empty_s),
    .count (in_count_s)
  );

  nic_fifo #(.DEPTH(DEPTH), .DW(DW)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_out_s),
    .pop   (net_so_s),
    .din   (d_in),
    .dout  (out_head_s),
    .full  (out_full_s),
    .empty (out_empty_s),
    .count (out_count_s)
  );

  // Register-file read mux; d_out holds when no read is issued.
  always_comb begin
    d_out_nxt_s = d_out_r;
    if (rd_s) begin
      case (addr)
        ADDR_IN_BUF:   d_out_nxt_s = in_empty_s ? {DW{1'b0}} : in_head_s;
        ADDR_IN_STAT:  d_out_nxt_s = {{(DW-6){1'b0}}, in_cnt5_s, !in_empty_s};
        ADDR_OUT_BUF:  d_out_nxt_s = {DW{1'b0}};
        ADDR_OUT_STAT: d_out_nxt_s = {{(DW-6){1'b0}}, out_cnt5_s, out_full_s};
        default:       d_out_nxt_s = {DW{1'b0}};
      endcase
    end else begin
      d_out_nxt_s = d_out_r;
    end
  end

  // Registered processor read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_r <= {DW{1'b0}};
    end else begin
      d_out_r <= d_out_nxt_s;
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Scoreboard bench for pe_nic: stimulus pushes expected read data and
// expected outgoing packets into queues; monitors pop and compare.
module tb_pe_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int vectors = 0;
  int errors  = 0;

  logic [63:0] rq[$];
  logic [63:0] sq[$];
  logic        rd_pend = 1'b0;

  pe_nic #(.DEPTH(2), .DW(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  always #5 clk = ~clk;

  // Router polarity alternates every cycle.
  initial begin
    net_polarity = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      net_polarity = ~net_polarity;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A read response is due one cycle after the access.
  always @(posedge clk) rd_pend <= (nicEn === 1'b1) && (nicWrEn === 1'b0) && (reset === 1'b0);

  // Monitor: compare read data and outgoing packets against the queues.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rd_pend) begin
      if (rq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL rd_unexpected: got %h expected none", d_out);
      end else begin
        e = rq.pop_front();
        chk("rd_data", d_out, e);
      end
    end
    if (net_so === 1'b1) begin
      if (sq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL send_unexpected: got %h expected none", net_do);
      end else begin
        e = sq.pop_front();
        chk("send_data", net_do, e);
        chk("send_phase", {63'd0, net_polarity}, {63'd0, net_do[63]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] exp);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    rq.push_back(exp);
    cyc();
    nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v, input bit expect_send);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    if (expect_send) sq.push_back(v);
    cyc();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic rtr_push(input logic [63:0] v);
    net_si = 1'b1; net_di = v;
    cyc();
    net_si = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (((sq.size() != 0) || (rq.size() != 0)) && (n < 60)) begin
      cyc();
      n++;
    end
    vectors++;
    if ((sq.size() != 0) || (rq.size() != 0)) begin
      errors++;
      $display("FAIL %s: got %0d pending expected 0", name, sq.size() + rq.size());
      sq.delete();
      rq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; addr = 2'b00; d_in = 64'd0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_si = 1'b0; net_di = 64'd0;
    repeat (2) cyc();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_net_ri", {63'd0, net_ri}, 64'd1);
    chk("rst_net_so", {63'd0, net_so}, 64'd0);
    chk("rst_d_out", d_out, 64'd0);
    cyc();
    rd(2'b01, 64'd0);
    rd(2'b11, 64'd0);
    wait_drain("rst_status");

    // Single odd-VC packet
    net_ro = 1'b1;
    wr(2'b10, 64'h8000_0000_0000_00AA, 1'b1);
    wait_drain("odd_send");
    rd(2'b11, 64'd0);
    wait_drain("odd_status");

    // Even then odd, in order
    wr(2'b10, 64'h0000_0000_0000_0011, 1'b1);
    wr(2'b10, 64'h8000_0000_0000_0022, 1'b1);
    wait_drain("pair_send");

    // Overflow: third write dropped
    net_ro = 1'b0;
    wr(2'b10, 64'h0000_0000_0000_0001, 1'b1);
    wr(2'b10, 64'h0000_0000_0000_0002, 1'b1);
    wr(2'b10, 64'h0000_0000_0000_0003, 1'b0);
    rd(2'b11, 64'h5);
    cyc();
    net_ro = 1'b1;
    wait_drain("overflow_drain");
    rd(2'b11, 64'd0);
    rd(2'b10, 64'd0);
    wait_drain("out_empty");

    // Inbound fill and drain
    rtr_push(64'h0123);
    rtr_push(64'h4567);
    @(negedge clk);
    chk("in_full_ri", {63'd0, net_ri}, 64'd0);
    cyc();
    rd(2'b01, 64'h5);
    rd(2'b00, 64'h0123);
    rd(2'b00, 64'h4567);
    rd(2'b01, 64'd0);
    rd(2'b00, 64'd0);
    wr(2'b01, 64'hFFFF, 1'b0);
    wr(2'b00, 64'hFFFF, 1'b0);
    rd(2'b01, 64'd0);
    wait_drain("inbound");

    // Simultaneous inbound push and pop
    rtr_push(64'h0A);
    net_si = 1'b1; net_di = 64'h0B;
    rd(2'b00, 64'h0A);
    net_si = 1'b0;
    rd(2'b01, 64'h3);
    rd(2'b00, 64'h0B);
    wait_drain("in_simul");

    // Reset with data queued in both directions
    net_ro = 1'b0;
    wr(2'b10, 64'h0000_0000_0000_00C1, 1'b0);
    wr(2'b10, 64'h8000_0000_0000_00C2, 1'b0);
    rtr_push(64'h77);
    rtr_push(64'h88);
    rd(2'b00, 64'h77);
    wait_drain("pre_reset");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    net_ro = 1'b1;
    @(negedge clk);
    chk("mid_rst_net_so", {63'd0, net_so}, 64'd0);
    chk("mid_rst_net_ri", {63'd0, net_ri}, 64'd1);
    chk("mid_rst_d_out", d_out, 64'd0);
    cyc();
    rd(2'b01, 64'd0);
    rd(2'b11, 64'd0);
    repeat (3) cyc();
    wait_drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
